// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling factor, baud divisor.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned OS_W       = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_IDX_W  = 3;

  // Receive FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, truncated
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baudrate);
    return clk_freq / (baudrate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Valid/ready byte stream leaving the UART receive front-end.
interface uart_rx_frontend_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage contents
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer and storage registers; storage cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchroniser, 16x oversampling FSM, FWFT byte FIFO, sticky errors.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = 32000000,
  parameter int unsigned baudrate   = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RX,
  uart_rx_frontend_if.master        rx_if,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      err_clr,
  output logic                      rx_busy
);

  localparam int unsigned DIV     = uart_div(clk_freq, baudrate);
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_SAMPLE = OS_W'(7);

  logic                 sync1_q, rxs_q, rxs_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_busy_q, rx_busy_d;

  logic                 tick;
  logic                 sample;
  logic                 fall;
  logic                 push;
  logic                 fe_set;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BYTE_W-1:0]    fifo_rd_data;

  assign tick   = (cnt_q == CNT_MAX);
  assign sample = tick && (os_q == OS_SAMPLE);
  assign fall   = rxs_prev_q && !rxs_q;
  assign pop    = rx_if.rx_ready && !fifo_empty;

  // Two-flop synchroniser plus edge-detect history, all idling high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= RX;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receive FSM next state, tick/oversample counters and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    os_d      = tick ? os_q + OS_W'(1) : os_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Counters held at zero so the start bit is timed from its edge
        cnt_d     = '0;
        os_d      = '0;
        bit_idx_d = '0;
        if (fall) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sample) begin
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d = {rxs_q, shift_q[BYTE_W-1:1]};
          if (bit_idx_q == BIT_IDX_W'(7)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A break stays here until the line recovers, giving one error per break
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags (set beats clear) and busy indicator
  always_comb begin
    frame_err_d = fe_set || (frame_err_q && !err_clr);
    overrun_d   = (push && fifo_full && !pop) || (overrun_q && !err_clr);
    rx_busy_d   = (state_d != ST_IDLE);
  end

  // FSM, datapath and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      os_q        <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      os_q        <= os_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (shift_q),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_if.rx_data  = fifo_rd_data;
  assign rx_if.rx_valid = !fifo_empty;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign rx_busy        = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at a reduced clock so each bit is 128 clocks.
module tb_uart_rx_frontend;

  localparam int unsigned CLK_FREQ = 1228800;
  localparam int unsigned BAUD     = 9600;
  localparam int DIV     = 8;
  localparam int BIT     = 16 * DIV;
  // Negedge (counted from the start-edge negedge) just before the stop-bit sample edge
  localparam int POP_NEG = 2 + 152 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic RX = 1'b1;
  logic err_clr = 1'b0;
  logic frame_err, overrun, rx_busy;

  int tests = 0;
  int fails = 0;
  int fe_events = 0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_frontend_if rx_if();

  uart_rx_frontend #(
    .clk_freq   (CLK_FREQ),
    .baudrate   (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RX        (RX),
    .rx_if     (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drive one 8N1 frame; called on a negedge, returns on a negedge with the line high
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compare every accepted byte against the scoreboard, count frame_err events
  always @(negedge clk) begin
    #2;
    if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_events++;
    fe_prev = frame_err;
    if (!reset && rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected actual=0x%02h required=no_byte", rx_if.rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_if.rx_data !== exp_b) begin
          fails++;
          $display("FAIL pop_data actual=0x%02h required=0x%02h", rx_if.rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", rx_if.rx_valid, 0);
    check("reset_rx_data", rx_if.rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_rx_busy", rx_busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Two good frames back to back
    rx_if.rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    wait_drain(4 * BIT);
    check("good_frame_err", frame_err, 0);
    check("good_overrun", overrun, 0);

    // Start-bit glitch shorter than half a bit
    RX = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_high", rx_busy, 1);
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (BIT) @(negedge clk);
    check("glitch_busy_low", rx_busy, 0);
    check("glitch_no_byte", rx_if.rx_valid, 0);
    check("glitch_frame_err", frame_err, 0);

    // Stop bit low, then a break with err_clr colliding with the set
    send_byte(8'h3C, 1'b0);
    check("stop_low_frame_err", frame_err, 1);
    check("stop_low_no_byte", rx_if.rx_valid, 0);
    repeat (8) @(negedge clk);
    check("stop_low_events", fe_events, 1);
    pulse_clr();
    check("err_clr_frame_err", frame_err, 0);
    fork
      begin
        RX = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        RX = 1'b1;
      end
      begin
        repeat (POP_NEG) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_beats_clr", frame_err, 1);
      end
    join
    repeat (2 * BIT) @(negedge clk);
    check("break_events", fe_events, 2);
    check("break_frame_err", frame_err, 1);
    check("break_no_byte", rx_if.rx_valid, 0);
    check("break_busy_low", rx_busy, 0);
    pulse_clr();
    check("break_clr", frame_err, 0);

    // Overrun: fifth byte dropped with no consumer
    rx_if.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    check("ovr_overrun", overrun, 1);
    check("ovr_valid", rx_if.rx_valid, 1);
    check("ovr_head", rx_if.rx_data, 8'h01);
    rx_if.rx_ready = 1'b1;
    wait_drain(16);
    @(negedge clk);
    check("ovr_empty_after", rx_if.rx_valid, 0);
    rx_if.rx_ready = 1'b0;
    pulse_clr();
    check("ovr_clr", overrun, 0);

    // Full FIFO, pop coincides with the fifth byte's push
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_byte(8'h11 + 8'(i), 1'b1);
    end
    check("full_no_overrun_yet", overrun, 0);
    exp_q.push_back(8'h15);
    fork
      send_byte(8'h15, 1'b1);
      begin
        repeat (POP_NEG) @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
      end
    join
    check("pushpop_full_overrun", overrun, 0);
    check("pushpop_remaining", exp_q.size(), 4);
    rx_if.rx_ready = 1'b1;
    wait_drain(16);
    @(negedge clk);
    check("pushpop_empty_after", rx_if.rx_valid, 0);

    // Reset during bit 4 of 0xF0, then a clean 0x81
    RX = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    RX = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("midframe_busy", rx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_busy", rx_busy, 0);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("after_reset_valid", rx_if.rx_valid, 0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_drain(4 * BIT);
    check("after_reset_frame_err", frame_err, 0);
    check("after_reset_overrun", overrun, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
